// File: rtl/genius_control.sv
// ---------------------------------------------------------------------------
// genius_control
// Control FSM for the Genius (Simon) game. It sits directly upstream of the
// game datapath and sequences one game as follows:
//   setup -> FPGA playback -> user entry -> check -> next round / result.
//
// Parameters
//   SETTLE_CYCLES : cycles spent in S_CHECK before match/win are sampled
//                   (legal range 1..15).
//   ENTER_ACTIVE  : level of 'enter' that means the key is pressed.
//
// Ports
//   CLOCK_50  in   system clock, rising-edge active
//   reset     in   synchronous active-low reset
//   enter     in   synchronized ENTER key level (only the press edge matters)
//   end_FPGA  in   datapath: FPGA sequence playback finished
//   end_User  in   datapath: user has entered ROUND+1 symbols
//   end_time  in   datapath: user timer expired
//   win       in   datapath: final round reached with a correct sequence
//   match     in   datapath: user sequence equals FPGA sequence
//   R1        out  datapath global reset
//   R2        out  datapath per-round reset
//   E1        out  setup register load enable
//   E2        out  user-entry phase enable
//   E3        out  FPGA playback enable
//   E4        out  round counter increment (one-cycle pulse)
//   SEL       out  display select (0 = game view, 1 = result view)
//   state_o   out  current state encoding, for debug/LEDs
// ---------------------------------------------------------------------------
module genius_control #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          ENTER_ACTIVE  = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_SETUP  = 3'd1,
    S_SEQ    = 3'd2,
    S_PLAY   = 3'd3,
    S_CHECK  = 3'd4,
    S_NEXT   = 3'd5,
    S_RESULT = 3'd6
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // The state register is kept as a plain 3-bit vector so that the unused
  // encoding 7 is representable and can be steered back to S_INIT.
  logic [2:0] r_state;
  logic [3:0] r_settleCnt;
  logic       r_enterQ;
  state_e     w_nextState;
  logic       w_press;
  logic       w_settled;

  // A press is the first cycle the key reads active after reading inactive,
  // so holding the key down produces exactly one press.
  assign w_press   = (enter == ENTER_ACTIVE) && (r_enterQ != ENTER_ACTIVE);
  assign w_settled = (r_settleCnt == SETTLE_LAST);

  // State, settle counter and key history. The key history resets to the
  // pressed level so a key still held when reset is released is not seen
  // as a fresh press. The settle counter only runs inside S_CHECK and is
  // held at zero everywhere else, which clears it on every entry.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_settleCnt <= 4'd0;
      r_enterQ    <= ENTER_ACTIVE;
    end else begin
      r_state     <= w_nextState;
      r_enterQ    <= enter;
      if (r_state == S_CHECK) begin
        r_settleCnt <= r_settleCnt + 4'd1;
      end else begin
        r_settleCnt <= 4'd0;
      end
    end
  end

  // Next-state logic and Moore output decode. Outputs depend only on the
  // state register; the illegal encoding drives every strobe low and
  // returns to S_INIT on the next clock.
  always_comb begin
    w_nextState = S_INIT;
    R1          = 1'b0;
    R2          = 1'b0;
    E1          = 1'b0;
    E2          = 1'b0;
    E3          = 1'b0;
    E4          = 1'b0;
    SEL         = 1'b0;
    case (r_state)
      S_INIT: begin
        R1          = 1'b1;
        R2          = 1'b1;
        w_nextState = S_SETUP;
      end
      S_SETUP: begin
        E1          = 1'b1;
        w_nextState = w_press ? S_SEQ : S_SETUP;
      end
      S_SEQ: begin
        E3          = 1'b1;
        w_nextState = end_FPGA ? S_PLAY : S_SEQ;
      end
      S_PLAY: begin
        E2 = 1'b1;
        // end_User outranks end_time when both arrive together.
        if (end_User) begin
          w_nextState = S_CHECK;
        end else if (end_time) begin
          w_nextState = S_RESULT;
        end else begin
          w_nextState = S_PLAY;
        end
      end
      S_CHECK: begin
        if (!w_settled) begin
          w_nextState = S_CHECK;
        end else if (match && !win) begin
          w_nextState = S_NEXT;
        end else begin
          w_nextState = S_RESULT;
        end
      end
      S_NEXT: begin
        R2          = 1'b1;
        E4          = 1'b1;
        w_nextState = S_SEQ;
      end
      S_RESULT: begin
        SEL         = 1'b1;
        w_nextState = w_press ? S_INIT : S_RESULT;
      end
      default: begin
        w_nextState = S_INIT;
      end
    endcase
  end

  assign state_o = r_state;

endmodule

// File: doc/genius_control.md
Name: genius_control

Overview:
- Control FSM for the Genius (Simon) game, directly upstream of the game datapath.
- Drives the datapath's reset, enable and display-select strobes (R1, R2, E1–E4, SEL).
- Consumes the datapath status flags (end_FPGA, end_User, end_time, win, match) and the player's synchronized ENTER key.
- Sequences setup → FPGA playback → user entry → check → next round / result.

Parameters:
- SETTLE_CYCLES, 2, cycles spent in S_CHECK before sampling match/win (lets the compare path settle after end_User); legal range 1..15.
- ENTER_ACTIVE, 1, active level of the enter input (1 = high means pressed).

Ports:
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of CLOCK_50.
- enter  input  1  synchronized ENTER key level (KEY-derived); the FSM acts on the press edge only.
- end_FPGA  input  1  datapath: FPGA sequence playback finished.
- end_User  input  1  datapath: user has entered ROUND+1 symbols.
- end_time  input  1  datapath: user timer expired.
- win  input  1  datapath: final round reached with a correct sequence.
- match  input  1  datapath: user sequence equals FPGA sequence.
- R1  output  1  datapath global reset (setup, round counter, clock divider).
- R2  output  1  datapath per-round reset (timer, user/FPGA counters, sequence registers).
- E1  output  1  setup register load enable.
- E2  output  1  user-entry phase enable (timer, user counter/register).
- E3  output  1  FPGA playback enable.
- E4  output  1  round counter increment (single-cycle pulse).
- SEL  output  1  display select: 0 = game view (level/time/round), 1 = result view (FPGA/USEr + points).
- state_o  output  3  current state encoding, for debug/LEDs.

Behaviour:
- States and encodings: S_INIT=0, S_SETUP=1, S_SEQ=2, S_PLAY=3, S_CHECK=4, S_NEXT=5, S_RESULT=6. Encoding 7 is illegal and recovers to S_INIT on the next clock.
- Outputs are Moore outputs, decoded only from the state register. No output depends combinationally on any input.
- Output table; any signal not listed is 0:
  - S_INIT: R1=1, R2=1.
  - S_SETUP: E1=1.
  - S_SEQ: E3=1.
  - S_PLAY: E2=1.
  - S_CHECK: all 0.
  - S_NEXT: R2=1, E4=1.
  - S_RESULT: SEL=1.
- Reset: while reset=0 at a clock edge:
  - state ← S_INIT, so outputs are R1=1, R2=1, all else 0, state_o=0.
  - settle counter ← 0.
  - enter-history register ← pressed level, so a key already held at reset release is not treated as a press.
- Press detect: press = (enter==ENTER_ACTIVE) && (enter_q!=ENTER_ACTIVE), where enter_q is enter registered one cycle. Result is one pulse per press, regardless of hold length.
- Transitions (evaluated at each clock edge):
  - S_INIT → S_SETUP unconditionally. S_INIT lasts exactly 1 cycle.
  - S_SETUP → S_SEQ on press; otherwise hold.
  - S_SEQ → S_PLAY when end_FPGA=1; otherwise hold.
  - S_PLAY → S_CHECK when end_User=1. Else S_PLAY → S_RESULT when end_time=1. Otherwise hold.
  - If end_User and end_time are both 1 in the same cycle, end_User has priority (go to S_CHECK).
  - S_CHECK: the counter increments each cycle. When counter==SETTLE_CYCLES-1:
    - match=0 → S_RESULT;
    - match=1, win=1 → S_RESULT;
    - match=1, win=0 → S_NEXT.
  - The settle counter clears on every entry to S_CHECK.
  - S_NEXT → S_SEQ unconditionally. E4 is a 1-cycle pulse; R2 clears the per-round datapath state for the same cycle.
  - S_RESULT → S_INIT on press; otherwise hold.
- Presses in any state other than S_SETUP/S_RESULT are ignored and not queued.
- Reset mid-operation (any state): next state is S_INIT; no pending press or counter value survives.
- Latency:
  - Press in S_SETUP → E3 asserted on the following cycle.
  - end_User in S_PLAY → decision SETTLE_CYCLES+1 cycles later.

Test Plan:
- Reset held low 3 cycles, then released → state_o=0, R1=R2=1 for one cycle; then state_o=1 and E1=1. With enter held high through reset, no advance occurs until enter goes low and high again.
- S_SETUP, enter pulses 1 → state_o=2, E3=1 next cycle. end_FPGA=1 → state_o=3, E2=1. Holding enter high 10 cycles causes no further transitions.
- S_PLAY, end_User=1, match=1, win=0, SETTLE_CYCLES=2 → S_CHECK for 2 cycles, then S_NEXT for exactly 1 cycle (E4=1, R2=1), then state_o=2.
- S_PLAY, end_User=1, match=0 → after the check, state_o=6, SEL=1. A press returns to S_INIT, then S_SETUP.
- S_PLAY, end_time=1 and end_User=1 in the same cycle, match=1, win=1 → goes to S_CHECK (not directly to S_RESULT), then S_RESULT with SEL=1.
- Reset=0 asserted for 1 cycle while in S_SEQ with E3=1 → next cycle state_o=0, E3=0, R1=R2=1. State encoding 7 forced via the bench → S_INIT next cycle.
